spawn_scheduler: RTL

Frame-based scheduler that shares the single keystroke-driven pseudo-random source (4-bit, 0–15) among the lane spawners of the game. Once per frame it grants up to a fixed number of requesting lanes, in round-robin order. Each granted lane receives a range-reduced, non-repeating random value, and a per-lane cooldown enforces a minimum frame gap between that lane's spawns. It sits between the random generator and the lane/object spawn logic, clocked in the pixel/game clock domain.

---
 rtl/spawn_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spawn_scheduler.sv
// spawn_scheduler
//   Frame-based round-robin scheduler that shares one 4-bit pseudo-random
//   source among the lane spawners. Each frame it grants up to
//   GRANTS_PER_FRAME requesting lanes, one per cycle. Each granted lane gets a
//   range-reduced value that differs from the lane's previous value. A
//   per-lane cooldown enforces a minimum frame gap between spawns on a lane.
//
// Ports
//   clk          clock (pixel/game domain)
//   resetN       asynchronous, active-low reset
//   startOfFrame one-cycle pulse at frame start
//   enable       run/pause; low forces IDLE and freezes cooldowns and rr_ptr
//   random       pseudo-random input, sampled in the pick cycle
//   req          per-lane level request
//   gnt          registered one-hot grant pulse
//   value        registered spawn value, valid with gnt, otherwise 0
//   busy         high while the scheduler is scanning
module spawn_scheduler #(
    parameter int N_LANES          = 4,
    parameter int RANGE            = 12,
    parameter int COOLDOWN_FRAMES  = 3,
    parameter int GRANTS_PER_FRAME = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic [3:0]         random,
    input  logic [N_LANES-1:0] req,
    output logic [N_LANES-1:0] gnt,
    output logic [3:0]         value,
    output logic               busy
);

    localparam int          PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int          GW = $clog2(GRANTS_PER_FRAME + 1);
    localparam int unsigned NL = N_LANES;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      rr_ptr, pick;
    logic [GW-1:0]      gcount, gcount_n;
    logic [5:0]         cooldown [N_LANES];
    logic [3:0]         last     [N_LANES];
    logic [N_LANES-1:0] elig;
    logic               found, do_grant, frame_tick;
    logic [3:0]         r_red, v;
    int unsigned        idx;

    assign frame_tick = startOfFrame && enable;
    assign busy       = (state == SCAN);

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            elig[i] = req[i] && (cooldown[i] == '0);
        end
    end

    // First eligible lane at or after rr_ptr, wrapping at N_LANES
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned j = 0; j < NL; j++) begin
            idx = (32'(rr_ptr) + j) % NL;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Range reduction, then bump by one (wrapping) to avoid repeating the lane's last value
    always_comb begin
        r_red = random;
        if ({1'b0, random} >= 5'(RANGE)) begin
            r_red = random - 4'(RANGE);
        end
        v = r_red;
        if (r_red == last[pick]) begin
            v = (r_red == 4'(RANGE - 1)) ? 4'd0 : r_red + 4'd1;
        end
    end

    // A frame pulse inside SCAN restarts the frame: the grant count starts over
    // and includes any grant picked in that same cycle.
    always_comb begin
        state_n  = state;
        gcount_n = gcount;
        do_grant = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startOfFrame) begin
                        state_n  = SCAN;
                        gcount_n = '0;
                    end
                end
                SCAN: begin
                    do_grant = found;
                    gcount_n = (startOfFrame ? '0 : gcount) + GW'(found);
                    if (startOfFrame) begin
                        if (found && gcount_n >= GW'(GRANTS_PER_FRAME)) begin
                            state_n = IDLE;
                        end
                    end else if (!found || gcount_n >= GW'(GRANTS_PER_FRAME)) begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gnt    <= '0;
            value  <= '0;
            rr_ptr <= '0;
            gcount <= '0;
            for (int unsigned i = 0; i < NL; i++) begin
                cooldown[i] <= '0;
                last[i]     <= '0;
            end
        end else begin
            gcount <= gcount_n;
            gnt    <= '0;
            value  <= '0;
            if (frame_tick) begin
                for (int unsigned i = 0; i < NL; i++) begin
                    if (cooldown[i] != '0) begin
                        cooldown[i] <= cooldown[i] - 6'd1;
                    end
                end
            end
            // Grant load follows the decrement so it wins for the granted lane
            if (do_grant) begin
                gnt[pick]      <= 1'b1;
                value          <= v;
                last[pick]     <= v;
                cooldown[pick] <= 6'(COOLDOWN_FRAMES);
                rr_ptr         <= (pick == PW'(NL - 1)) ? '0 : pick + 1'b1;
            end
        end
    end

endmodule
